// File: rtl/adc_sequencer.sv
// adc_sequencer: SPI-style front end for a 12-bit serial ADC that delivers
// 16-bit frames, MSB first.
//
// The block drops CS, clocks out 16 SCLK periods and captures SDATA on each
// SCLK rising edge. It then presents the frame on b_reg/data_Out with a
// valid/overrun handshake and keeps CS high for a guaranteed quiet gap.
// Frames start on a level enable (continuous mode) or on a single start pulse.
// A start pulse that arrives while a frame is in progress is remembered.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           continuous-conversion enable (level)
//   start        single-conversion request (one-clk pulse)
//   rd_ack       consumer acknowledge; clears valid/overrun
//   SDATA        serial data from ADC (changes on SCLK falling edges)
//   SCLK, CS     registered serial clock (idles high) and chip select (active low)
//   busy         state is not IDLE
//   rx_done_tick one-clk pulse in the cycle a frame is delivered
//   b_reg        last complete 16-bit frame
//   data_Out     b_reg[11:4], the 8 MSBs of the 12-bit sample
//   valid        unread sample present
//   overrun      sticky: a sample was overwritten while still unread
`timescale 1ns/1ps

module adc_sequencer #(
    parameter int SCLK_HALF = 4,   // clk cycles per SCLK half-period, 2..255
    parameter int QUIET_CYC = 8    // clk cycles in QUIET, 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        start,
    input  logic        rd_ack,
    input  logic        SDATA,
    output logic        SCLK,
    output logic        CS,
    output logic        busy,
    output logic        rx_done_tick,
    output logic [15:0] b_reg,
    output logic [7:0]  data_Out,
    output logic        valid,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, FRAME, DONE, QUIET} state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCLK_HALF - 1);
    localparam logic [7:0] Q_LAST   = 8'(QUIET_CYC - 1);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [4:0]  r_edge;
    logic [7:0]  r_quiet;
    logic [15:0] r_shift;
    logic        r_start_pend;

    logic        w_quiet_end;
    logic        w_enter;
    logic        w_sclk_rise;
    logic [15:0] w_shift_nx;

    always_comb begin
        w_quiet_end = (r_quiet == Q_LAST);
        // Single place that decides a new frame begins, from IDLE or at QUIET end.
        w_enter = ((r_state == IDLE)  && (en || start || r_start_pend)) ||
                  ((r_state == QUIET) && w_quiet_end && (en || r_start_pend));
        // SCLK is currently low and the divider wraps: this edge drives it high.
        w_sclk_rise = (r_state == FRAME) && (r_div == DIV_LAST) && !SCLK;
        w_shift_nx  = {r_shift[14:0], SDATA};
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_edge       <= '0;
            r_quiet      <= '0;
            r_shift      <= '0;
            r_start_pend <= 1'b0;
            SCLK         <= 1'b1;
            CS           <= 1'b1;
            rx_done_tick <= 1'b0;
            b_reg        <= '0;
            data_Out     <= '0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;

            // In the DONE cycle a fresh sample was just posted; an ack seen
            // there belongs to the old sample and must not clear the new one.
            if (rd_ack && (r_state != DONE)) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (start && (r_state != IDLE))
                r_start_pend <= 1'b1;

            case (r_state)
                IDLE: ;
                FRAME: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        SCLK  <= ~SCLK;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                    if (w_sclk_rise) begin
                        r_shift <= w_shift_nx;
                        r_edge  <= r_edge + 5'd1;
                        if (r_edge == 5'd15) begin
                            // 16th rising edge: close CS and post the frame so it
                            // is already on b_reg while rx_done_tick is high.
                            r_state      <= DONE;
                            CS           <= 1'b1;
                            rx_done_tick <= 1'b1;
                            b_reg        <= w_shift_nx;
                            data_Out     <= w_shift_nx[11:4];
                            valid        <= 1'b1;
                            if (valid && !rd_ack)
                                overrun <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= QUIET;
                    r_quiet <= '0;
                end
                QUIET: begin
                    if (w_quiet_end)
                        r_state <= IDLE;
                    else
                        r_quiet <= r_quiet + 8'd1;
                end
                default: r_state <= IDLE;
            endcase

            // Frame entry overrides the per-state updates above.
            if (w_enter) begin
                r_state      <= FRAME;
                CS           <= 1'b0;
                SCLK         <= 1'b1;
                r_div        <= '0;
                r_edge       <= '0;
                r_start_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
`timescale 1ns/1ps

module tb_adc_sequencer;

    localparam int SH     = 4;
    localparam int QC     = 8;
    localparam int PERIOD = 32*SH + 1 + QC;   // 137

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, start = 1'b0, rd_ack = 1'b0, SDATA = 1'b0;
    logic        SCLK, CS, busy, rx_done_tick, valid, overrun;
    logic [15:0] b_reg;
    logic [7:0]  data_Out;

    adc_sequencer #(.SCLK_HALF(SH), .QUIET_CYC(QC)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .rd_ack(rd_ack),
        .SDATA(SDATA), .SCLK(SCLK), .CS(CS), .busy(busy),
        .rx_done_tick(rx_done_tick), .b_reg(b_reg), .data_Out(data_Out),
        .valid(valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        logic        ovr;
        int          gap;   // required clk distance from previous tick, 0 = skip
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] adc_q[$];
    logic [15:0] adc_word = 16'h0;
    int          adc_idx = 0;
    int          pass_cnt = 0, fail_cnt = 0;
    int          cyc = 0, ticks = 0, last_tick = 0, sclk_rises = 0;
    logic        prev_tick = 1'b0;
    int          cs_low, n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act === req) pass_cnt++;
        else begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] b, input logic ovr, input int gap);
        exp_t e;
        e.b = b; e.ovr = ovr; e.gap = gap;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: loads the next word when CS falls, shifts MSB first on SCLK falls.
    always @(negedge CS) begin
        adc_idx = 15;
        if (adc_q.size() > 0) adc_word = adc_q.pop_front();
        else                  adc_word = 16'h0;
    end
    always @(negedge SCLK) begin
        if (CS == 1'b0 && adc_idx >= 0) begin
            SDATA = adc_word[adc_idx];
            adc_idx--;
        end
    end
    always @(posedge SCLK) sclk_rises++;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && rx_done_tick === 1'b1) begin
            ticks++;
            chk("tick_not_back_to_back", {31'd0, prev_tick}, 32'd0);
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_tick: b_reg=%h, no frame expected", b_reg);
            end else begin
                mon_e = exp_q.pop_front();
                chk("b_reg", {16'd0, b_reg}, {16'd0, mon_e.b});
                chk("data_Out", {24'd0, data_Out}, {24'd0, mon_e.b[11:4]});
                chk("valid_at_tick", {31'd0, valid}, 32'd1);
                chk("overrun_at_tick", {31'd0, overrun}, {31'd0, mon_e.ovr});
                if (mon_e.gap != 0) chk("tick_spacing", cyc - last_tick, mon_e.gap);
            end
            last_tick = cyc;
        end
        prev_tick = rx_done_tick;
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1; @(negedge clk); rd_ack = 1'b0;
    endtask

    task automatic wait_tick(input string name, input int budget);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end
        while (rx_done_tick !== 1'b1 && k < budget);
        if (rx_done_tick !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s: no rx_done_tick within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        if (busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL %s: busy still high after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        cycles(3);
        chk("rst_CS", {31'd0, CS}, 32'd1);
        chk("rst_SCLK", {31'd0, SCLK}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tick", {31'd0, rx_done_tick}, 32'd0);
        chk("rst_b_reg", {16'd0, b_reg}, 32'd0);
        chk("rst_data_Out", {24'd0, data_Out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        cycles(10);
        chk("no_start_after_release_CS", {31'd0, CS}, 32'd1);
        chk("no_start_after_release_busy", {31'd0, busy}, 32'd0);

        // Single conversion 0x0ABC
        adc_q.push_back(16'h0ABC); push_exp(16'h0ABC, 1'b0, 0);
        sclk_rises = 0;
        pulse_start();
        cs_low = 0;
        while (CS == 1'b0 && cs_low < 1000) begin cs_low++; @(negedge clk); end
        chk("single_cs_low_cycles", cs_low, 32*SH);
        chk("single_sclk_rises", sclk_rises, 16);
        wait_idle("single_idle", 40);
        chk("single_busy", {31'd0, busy}, 32'd0);
        chk("single_valid", {31'd0, valid}, 32'd1);
        cycles(20);
        chk("single_no_refire_CS", {31'd0, CS}, 32'd1);
        ack_pulse();
        chk("single_ack_clears_valid", {31'd0, valid}, 32'd0);

        // Continuous mode with ack after each tick
        adc_q.push_back(16'h0123); adc_q.push_back(16'h0456); adc_q.push_back(16'h0789);
        push_exp(16'h0123, 1'b0, 0);
        push_exp(16'h0456, 1'b0, PERIOD);
        push_exp(16'h0789, 1'b0, PERIOD);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_tick("cont_tick", 300);
            if (i == 2) en = 1'b0;
            cycles(1);
            ack_pulse();
        end
        wait_idle("cont_idle", 40);
        chk("cont_overrun", {31'd0, overrun}, 32'd0);
        chk("cont_valid_acked", {31'd0, valid}, 32'd0);

        // Overrun: two frames, no ack
        adc_q.push_back(16'h0F0F); adc_q.push_back(16'h0A55);
        push_exp(16'h0F0F, 1'b0, 0);
        push_exp(16'h0A55, 1'b1, PERIOD);
        en = 1'b1;
        wait_tick("ovr_tick1", 300);
        wait_tick("ovr_tick2", 300);
        en = 1'b0;
        wait_idle("ovr_idle", 40);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        chk("ovr_b_reg_second", {16'd0, b_reg}, 32'h0A55);
        ack_pulse();
        chk("ovr_ack_valid", {31'd0, valid}, 32'd0);
        chk("ovr_ack_overrun", {31'd0, overrun}, 32'd0);

        // rd_ack on the edge into DONE and through the DONE cycle, prior sample unread
        adc_q.push_back(16'h0C3C); push_exp(16'h0C3C, 1'b0, 0);
        pulse_start();
        wait_tick("ackdone_pre_tick", 300);
        wait_idle("ackdone_pre_idle", 40);
        chk("ackdone_prior_valid", {31'd0, valid}, 32'd1);
        adc_q.push_back(16'h0E71); push_exp(16'h0E71, 1'b0, 0);
        pulse_start();
        cycles(32*SH - 1);
        rd_ack = 1'b1;
        cycles(2);
        rd_ack = 1'b0;
        chk("ackdone_valid", {31'd0, valid}, 32'd1);
        chk("ackdone_overrun", {31'd0, overrun}, 32'd0);
        wait_idle("ackdone_idle", 40);

        // Reset at the 10th SCLK rising edge
        adc_q.push_back(16'h0FFF);
        sclk_rises = 0;
        pulse_start();
        n = 0;
        while (sclk_rises < 10 && n < 500) begin @(negedge clk); n++; end
        chk("midrst_reached_10_rises", sclk_rises, 10);
        #1 reset = 1'b0;
        #1;
        chk("midrst_CS_async", {31'd0, CS}, 32'd1);
        chk("midrst_SCLK_async", {31'd0, SCLK}, 32'd1);
        chk("midrst_tick", {31'd0, rx_done_tick}, 32'd0);
        chk("midrst_b_reg", {16'd0, b_reg}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        cycles(3);
        reset = 1'b1;
        adc_q.delete();
        cycles(20);
        chk("midrst_release_CS", {31'd0, CS}, 32'd1);
        chk("midrst_release_busy", {31'd0, busy}, 32'd0);

        // Two start pulses during QUIET yield exactly one more frame
        adc_q.push_back(16'h0321); adc_q.push_back(16'h0654);
        push_exp(16'h0321, 1'b0, 0);
        push_exp(16'h0654, 1'b0, PERIOD);
        pulse_start();
        wait_tick("pend_tick_a", 300);
        cycles(1);
        rd_ack = 1'b1; @(negedge clk); rd_ack = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        cycles(2);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_tick("pend_tick_b", 300);
        wait_idle("pend_idle", 40);
        cycles(200);
        chk("pend_no_extra_CS", {31'd0, CS}, 32'd1);
        chk("pend_no_extra_busy", {31'd0, busy}, 32'd0);

        chk("total_ticks", ticks, 10);
        chk("all_expected_delivered", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
